tt_um_inv_bank: RTL and testbench
=================================

TT_UM_INV_BANK -- requirements
Module: tt_um_inv_bank

Interface
REQ-001 Parameter NCH, default 8: number of active channels, legal 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal 2..3.
REQ-003 Parameter STRETCH_LEN, default 8: pulse-stretch length in cycles, legal 1..255.
REQ-004 Port clk  input  1  single clock; all state on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port ena  input  1  always 1 when powered; ignored.
REQ-007 Port ui_in  input  8  channel inputs; bit i feeds channel i; bits >= NCH unused.
REQ-008 Port uo_out  output  8  channel outputs; bit i from channel i; bits >= NCH tied 0.
REQ-009 Port uio_in  input  8  config bus: [7] cfg_wr strobe, [6:4] channel index, [3:2] mode; [1:0] unused.
REQ-010 Port uio_out  output  8  status: [0] cfg_ack, [1] any_active; [7:2] tied 0.
REQ-011 Port uio_oe  output  8  constant 8'b0000_0011.

Function
REQ-012 Each channel input SHALL pass through a SYNC_STAGES flop synchroniser; the synchronised value is sin[i].
REQ-013 Each channel SHALL hold a delayed copy of sin[i] for rising-edge detection (rise = sin & ~sin_d).
REQ-014 Modes SHALL be: 00 PASS (out = sin), 01 INV (out = ~sin), 10 TOGGLE (out flips on each rise), 11 STRETCH (out high while stretch counter != 0).
REQ-015 uo_out[i] SHALL be registered; PASS/INV latency from ui_in change to uo_out change SHALL be SYNC_STAGES+1 cycles.
REQ-016 In STRETCH, a rise SHALL load the counter with STRETCH_LEN; the counter decrements by 1 per cycle to 0; a rise while nonzero SHALL reload (retrigger).
REQ-017 STRETCH output SHALL go high the cycle after the rise is seen and stay high exactly STRETCH_LEN cycles absent retrigger.
REQ-018 In TOGGLE the toggle bit SHALL flip once per rise; a held-high input SHALL not flip it again.
REQ-019 cfg_wr SHALL be synchronised (SYNC_STAGES) and edge-detected; a config write occurs only on its synchronised rising edge.
REQ-020 Channel index and mode SHALL be sampled through the same synchroniser depth as cfg_wr, on the cycle of the write.
REQ-021 On a write with index < NCH, that channel's mode SHALL update, its toggle bit and stretch counter clear to 0, and the new mode applies from the next cycle.
REQ-022 On a write with index >= NCH, no state SHALL change and no ack SHALL be issued.
REQ-023 cfg_ack SHALL be a registered one-cycle pulse in the cycle after an accepted write.
REQ-024 A rise on a channel in the same cycle as a write to that channel SHALL be discarded (write wins).
REQ-025 any_active SHALL be the registered OR of uo_out[NCH-1:0].
REQ-026 Holding cfg_wr high SHALL produce exactly one write.

Reset
REQ-027 rst_n low SHALL asynchronously clear synchronisers, edge-history flops, toggle bits, stretch counters, uo_out, cfg_ack and any_active to 0.
REQ-028 Reset SHALL set every channel mode to INV (01).
REQ-029 With ui_in = 0 after reset release, uo_out[NCH-1:0] SHALL become all ones exactly 1 cycle after release.
REQ-030 Reset asserted mid-stretch or mid-write SHALL abort it; no ack SHALL follow.

Structure
REQ-031 Package tt_inv_bank_pkg SHALL hold the mode enum (PASS, INV, TOGGLE, STRETCH), config-bus field positions and the uio_oe constant.
REQ-032 Sub-module inv_bank_chan SHALL implement one channel (synchroniser, edge detect, mode register, toggle, stretch counter, output flop), generated NCH times.
REQ-033 Config decode, ack and any_active SHALL live in the top level.

Verification
REQ-034 Reset, ui_in=0x00 -> uo_out=0x00 during reset, 0xFF 1 cycle after release; uio_oe=0x03.
REQ-035 Write ch2 PASS, ui_in[2] 0->1 -> uo_out[2] rises 3 cycles later (SYNC_STAGES=2), cfg_ack one pulse.
REQ-036 Write ch5 TOGGLE, three 4-cycle high pulses on ui_in[5] -> uo_out[5] sequence 1,0,1.
REQ-037 Write ch0 STRETCH, 1-cycle pulse -> uo_out[0] high 8 cycles; second pulse 5 cycles after first -> high 13 cycles total.
REQ-038 NCH=4, write index 6 -> no ack, modes unchanged, uo_out[7:4]=0 throughout.
REQ-039 Assert rst_n mid-stretch (counter=4) -> uo_out[0]=0 immediately, mode back to INV.

Source files
------------

// File: rtl/tt_inv_bank_pkg.sv
// tt_inv_bank_pkg
// Shared definitions for the inverter bank:
//   mode_e       - per-channel operating mode
//   CFG_*        - bit positions of the fields on the uio_in config bus
//   STATUS_*     - bit positions of the flags on uio_out
//   UIO_OE_VALUE - fixed direction mask for the bidirectional pins
package tt_inv_bank_pkg;

   typedef enum logic [1:0] {
      MODE_PASS    = 2'b00,
      MODE_INV     = 2'b01,
      MODE_TOGGLE  = 2'b10,
      MODE_STRETCH = 2'b11
   } mode_e;

   // Config bus layout on uio_in. Bits [1:0] carry nothing, so only
   // [7:2] pass through the synchroniser.
   localparam int CFG_WR_BIT  = 7;
   localparam int CFG_IDX_HI  = 6;
   localparam int CFG_IDX_LO  = 4;
   localparam int CFG_MODE_HI = 3;
   localparam int CFG_MODE_LO = 2;
   localparam int CFG_LSB     = 2;
   localparam int CFG_FIELD_W = CFG_WR_BIT - CFG_LSB + 1;

   // Status layout on uio_out.
   localparam int STATUS_ACK_BIT = 0;
   localparam int STATUS_ANY_BIT = 1;

   // uio[1:0] drive status; uio[7:2] are config inputs.
   localparam logic [7:0] UIO_OE_VALUE = 8'b0000_0011;

endpackage

// File: rtl/inv_bank_chan.sv
// inv_bank_chan
// One channel of the inverter bank: input synchroniser, rising-edge
// detect, mode register, toggle bit, stretch counter and output flop.
// Ports:
//   clk     - clock, all state on its rising edge
//   rst_n   - asynchronous active-low reset
//   i_in    - raw (asynchronous) channel input
//   i_wr    - one-cycle config write aimed at this channel
//   i_mode  - mode to load when i_wr is high
//   o_out   - registered channel output
module inv_bank_chan
   import tt_inv_bank_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH_LEN = 8
)(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_in,
   input  logic  i_wr,
   input  mode_e i_mode,
   output logic  o_out
);

   localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_LEN);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sinD;
   mode_e                  r_mode;
   logic                   r_tog;
   logic [7:0]             r_cnt;
   logic                   r_out;

   logic       w_sin;
   logic       w_rise;
   mode_e      w_mode;
   logic       w_togNext;
   logic [7:0] w_cntNext;
   logic       w_outNext;

   assign w_sin = r_sync[SYNC_STAGES-1];
   assign o_out = r_out;

   // Next-state logic. A write to this channel clears the toggle bit and
   // stretch counter and swallows any rise seen in the same cycle, so the
   // freshly written mode always starts from a clean state. The output
   // flop is loaded using the new mode so it reflects it from the next
   // cycle on.
   always_comb begin
      w_rise    = w_sin & ~r_sinD & ~i_wr;
      w_mode    = i_wr ? i_mode : r_mode;
      w_togNext = r_tog;
      w_cntNext = r_cnt;
      w_outNext = 1'b0;

      if (i_wr) begin
         w_togNext = 1'b0;
         w_cntNext = '0;
      end else begin
         if (r_mode == MODE_TOGGLE && w_rise) begin
            w_togNext = ~r_tog;
         end
         if (r_mode == MODE_STRETCH && w_rise) begin
            w_cntNext = STRETCH_LOAD;
         end else if (r_cnt != 8'd0) begin
            w_cntNext = r_cnt - 8'd1;
         end
      end

      case (w_mode)
         MODE_PASS:    w_outNext = w_sin;
         MODE_INV:     w_outNext = ~w_sin;
         MODE_TOGGLE:  w_outNext = w_togNext;
         MODE_STRETCH: w_outNext = (w_cntNext != 8'd0);
         default:      w_outNext = 1'b0;
      endcase
   end

   // State registers. Reset leaves the channel inverting a quiet input,
   // so the output comes up high on the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_sinD <= 1'b0;
         r_mode <= MODE_INV;
         r_tog  <= 1'b0;
         r_cnt  <= '0;
         r_out  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
         r_sinD <= w_sin;
         r_mode <= w_mode;
         r_tog  <= w_togNext;
         r_cnt  <= w_cntNext;
         r_out  <= w_outNext;
      end
   end

endmodule

// File: rtl/tt_um_inv_bank.sv
// tt_um_inv_bank
// Bank of up to eight independently configurable channels (pass, invert,
// toggle on rise, pulse stretch) with a serial-free config bus.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   ena        - power-good, unused
//   ui_in      - channel inputs, bit i feeds channel i
//   uo_out     - channel outputs, bits >= NCH tied low
//   uio_in     - config bus: [7] write strobe, [6:4] channel, [3:2] mode
//   uio_out    - [0] write acknowledge pulse, [1] any output active
//   uio_oe     - constant direction mask
module tt_um_inv_bank
   import tt_inv_bank_pkg::*;
#(
   parameter int NCH         = 8,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH_LEN = 8
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [SYNC_STAGES-1:0][CFG_FIELD_W-1:0] r_cfgSync;
   logic                                    r_wrD;
   logic                                    r_ack;
   logic                                    r_any;

   logic [CFG_FIELD_W-1:0] w_cfg;
   logic                   w_wrSync;
   logic                   w_wrRise;
   logic [2:0]             w_idx;
   mode_e                  w_mode;
   logic                   w_accept;
   logic [7:0]             w_chanWr;
   logic [7:0]             w_out;
   logic                   w_unused;

   assign w_cfg    = r_cfgSync[SYNC_STAGES-1];
   assign w_wrSync = w_cfg[CFG_WR_BIT - CFG_LSB];
   assign w_wrRise = w_wrSync & ~r_wrD;
   assign w_idx    = w_cfg[CFG_IDX_HI - CFG_LSB : CFG_IDX_LO - CFG_LSB];
   assign w_mode   = mode_e'(w_cfg[CFG_MODE_HI - CFG_LSB : CFG_MODE_LO - CFG_LSB]);
   assign w_accept = w_wrRise && ({1'b0, w_idx} < 4'(NCH));
   assign w_unused = &{1'b0, ena, uio_in[1:0]};

   // Strobe, index and mode share one synchroniser so the fields seen on
   // the write edge all came from the same bus sample. Holding the strobe
   // high yields a single write because only its rising edge counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfgSync <= '0;
         r_wrD     <= 1'b0;
      end else begin
         r_cfgSync <= {r_cfgSync[SYNC_STAGES-2:0], uio_in[CFG_WR_BIT:CFG_LSB]};
         r_wrD     <= w_wrSync;
      end
   end

   // One-hot write select; an out-of-range index selects nothing.
   always_comb begin
      w_chanWr = '0;
      if (w_accept) begin
         w_chanWr[w_idx] = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_chan
         if (gi < NCH) begin : g_active
            inv_bank_chan #(
               .SYNC_STAGES (SYNC_STAGES),
               .STRETCH_LEN (STRETCH_LEN)
            ) u_chan (
               .clk    (clk),
               .rst_n  (rst_n),
               .i_in   (ui_in[gi]),
               .i_wr   (w_chanWr[gi]),
               .i_mode (w_mode),
               .o_out  (w_out[gi])
            );
         end else begin : g_idle
            assign w_out[gi] = 1'b0;
         end
      end
   endgenerate

   // Status flags. Unused channels drive 0, so OR-ing all eight bits is
   // the same as OR-ing the active ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack <= 1'b0;
         r_any <= 1'b0;
      end else begin
         r_ack <= w_accept;
         r_any <= |w_out;
      end
   end

   always_comb begin
      uio_out                 = '0;
      uio_out[STATUS_ACK_BIT] = r_ack;
      uio_out[STATUS_ANY_BIT] = r_any;
   end

   assign uo_out = w_out;
   assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_inv_bank.sv
`timescale 1ns/1ps
// tb_tt_um_inv_bank
// Two instances (8 and 4 channels) share one stimulus stream. A reference
// model built from input histories and stretch deadlines predicts both
// instances every clock; a monitor compares on the falling edge.
module tb_tt_um_inv_bank;

   localparam int S     = 2;
   localparam int L     = 8;
   localparam int NCH_A = 8;
   localparam int NCH_B = 4;

   localparam logic [1:0] M_PASS = 2'd0;
   localparam logic [1:0] M_INV  = 2'd1;
   localparam logic [1:0] M_TOG  = 2'd2;
   localparam logic [1:0] M_STR  = 2'd3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena   = 1'b1;
   logic [7:0] ui_in  = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uoA, uioA, oeA;
   logic [7:0] uoB, uioB, oeB;

   always #5 clk = ~clk;

   tt_um_inv_bank #(.NCH(NCH_A), .SYNC_STAGES(S), .STRETCH_LEN(L)) dutA (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uoA),
      .uio_in(uio_in), .uio_out(uioA), .uio_oe(oeA)
   );

   tt_um_inv_bank #(.NCH(NCH_B), .SYNC_STAGES(S), .STRETCH_LEN(L)) dutB (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uoB),
      .uio_in(uio_in), .uio_out(uioB), .uio_oe(oeB)
   );

   int checks = 0;
   int errors = 0;
   bit hiB    = 0;

   // Reference model state
   typedef struct packed { logic [7:0] uo; logic [7:0] uio; } exp_t;
   exp_t       expA[$];
   exp_t       expB[$];
   exp_t       eMon;
   logic [7:0] uHist[$];
   logic [5:0] cHist[$];
   int         edgeNum;
   logic [1:0] mMode[2][8];
   bit         mTog[2][8];
   int         mEnd[2][8];
   logic [7:0] mPrevOut[2];

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] uAt(input int k);
      return (k < 0) ? 8'h00 : uHist[k];
   endfunction

   function automatic logic [5:0] cAt(input int k);
      return (k < 0) ? 6'h00 : cHist[k];
   endfunction

   task automatic modelReset();
      uHist.delete();
      cHist.delete();
      expA.delete();
      expB.delete();
      edgeNum = 0;
      for (int i = 0; i < 2; i++) begin
         mPrevOut[i] = 8'h00;
         for (int c = 0; c < 8; c++) begin
            mMode[i][c] = M_INV;
            mTog[i][c]  = 1'b0;
            mEnd[i][c]  = 0;
         end
      end
   endtask

   // The synchronised value during the cycle ending at edge n is the
   // input sampled S edges earlier; a write lands when the sampled
   // strobe goes 0 -> 1 in that delayed stream.
   task automatic modelEdge();
      logic [7:0] sinCur, sinPrev, outV;
      logic [5:0] cCur, cPrev;
      logic       wrRise, accept;
      int         idx, nch;
      logic [1:0] nm;
      exp_t       e;
      uHist.push_back(ui_in);
      cHist.push_back(uio_in[7:2]);
      sinCur  = uAt(edgeNum - S);
      sinPrev = uAt(edgeNum - S - 1);
      cCur    = cAt(edgeNum - S);
      cPrev   = cAt(edgeNum - S - 1);
      wrRise  = cCur[5] & ~cPrev[5];
      idx     = int'(cCur[4:2]);
      nm      = cCur[1:0];
      for (int inst = 0; inst < 2; inst++) begin
         nch    = (inst == 0) ? NCH_A : NCH_B;
         accept = wrRise && (idx < nch);
         outV   = 8'h00;
         for (int ch = 0; ch < nch; ch++) begin
            if (accept && idx == ch) begin
               mMode[inst][ch] = nm;
               mTog[inst][ch]  = 1'b0;
               mEnd[inst][ch]  = 0;
            end else if (sinCur[ch] && !sinPrev[ch]) begin
               if (mMode[inst][ch] == M_TOG) mTog[inst][ch] = ~mTog[inst][ch];
               if (mMode[inst][ch] == M_STR) mEnd[inst][ch] = edgeNum + L;
            end
            case (mMode[inst][ch])
               M_PASS:  outV[ch] = sinCur[ch];
               M_INV:   outV[ch] = ~sinCur[ch];
               M_TOG:   outV[ch] = mTog[inst][ch];
               default: outV[ch] = (edgeNum < mEnd[inst][ch]);
            endcase
         end
         e.uo  = outV;
         e.uio = {6'b0, |mPrevOut[inst], accept};
         mPrevOut[inst] = outV;
         if (inst == 0) expA.push_back(e);
         else           expB.push_back(e);
      end
      edgeNum++;
   endtask

   always @(negedge rst_n) modelReset();

   always @(posedge clk) begin
      if (rst_n) modelEdge();
   end

   // Monitor: one prediction per clock per instance.
   always @(negedge clk) begin
      if (rst_n) begin
         if (expA.size() > 0) begin
            eMon = expA.pop_front();
            checkOutput("uo_out A", uoA, eMon.uo);
            checkOutput("uio_out A", uioA, eMon.uio);
         end
         if (expB.size() > 0) begin
            eMon = expB.pop_front();
            checkOutput("uo_out B", uoB, eMon.uo);
            checkOutput("uio_out B", uioB, eMon.uio);
         end
         if (uoB[7:4] != 4'h0) hiB = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] ui, input int cycles);
      ui_in = ui;
      tick(cycles);
   endtask

   // Holds the strobe high for several cycles and counts ack pulses.
   task automatic cfgWrite(input int idx, input logic [1:0] mode, input bit rnd,
                           output int ackA, output int ackB);
      ackA = 0;
      ackB = 0;
      uio_in = {1'b1, 3'(idx), mode, 2'b00};
      for (int k = 0; k < S + 4; k++) begin
         if (rnd) ui_in = 8'($urandom);
         tick(1);
         ackA += int'(uioA[0]);
         ackB += int'(uioB[0]);
      end
      uio_in[7] = 1'b0;
      tick(3);
   endtask

   logic [7:0] togExp[3];
   int aA, aB, cnt;

   initial begin
      togExp[0] = 8'd1;
      togExp[1] = 8'd0;
      togExp[2] = 8'd1;
      modelReset();
      #1 rst_n = 1'b0;
      tick(3);
      checkOutput("reset uo_out A", uoA, 8'h00);
      checkOutput("reset uio_out A", uioA, 8'h00);
      checkOutput("uio_oe A", oeA, 8'h03);
      checkOutput("uio_oe B", oeB, 8'h03);
      rst_n = 1'b1;
      tick(1);
      checkOutput("release uo_out A", uoA, 8'hFF);
      checkOutput("release uo_out B", uoB, 8'h0F);
      tick(2);

      // PASS latency on channel 2
      cfgWrite(2, M_PASS, 0, aA, aB);
      checkOutput("ack pass A", 8'(aA), 8'd1);
      checkOutput("ack pass B", 8'(aB), 8'd1);
      ui_in[2] = 1'b1;
      tick(2);
      checkOutput("pass early", {7'b0, uoA[2]}, 8'd0);
      tick(1);
      checkOutput("pass latency", {7'b0, uoA[2]}, 8'd1);
      applyStimulus(8'h00, 4);

      // TOGGLE on channel 5
      cfgWrite(5, M_TOG, 0, aA, aB);
      checkOutput("ack toggle A", 8'(aA), 8'd1);
      checkOutput("ack toggle B", 8'(aB), 8'd0);
      for (int p = 0; p < 3; p++) begin
         applyStimulus(8'h20, 4);
         applyStimulus(8'h00, 4);
         checkOutput($sformatf("toggle pulse %0d", p), {7'b0, uoA[5]}, togExp[p]);
      end

      // STRETCH on channel 0, single then retriggered
      cfgWrite(0, M_STR, 0, aA, aB);
      ui_in[0] = 1'b1;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         cnt += int'(uoA[0]);
         if (k == 0) ui_in[0] = 1'b0;
      end
      checkOutput("stretch length", 8'(cnt), 8'd8);
      ui_in[0] = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         tick(1);
         cnt += int'(uoA[0]);
         if (k == 0) ui_in[0] = 1'b0;
         if (k == 4) ui_in[0] = 1'b1;
         if (k == 5) ui_in[0] = 1'b0;
      end
      checkOutput("stretch retrigger", 8'(cnt), 8'd13);

      // Out-of-range index on the 4-channel instance
      cfgWrite(6, M_PASS, 0, aA, aB);
      checkOutput("ack idx6 A", 8'(aA), 8'd1);
      checkOutput("ack idx6 B", 8'(aB), 8'd0);
      applyStimulus(8'h00, 4);

      // Reset in the middle of a stretch (counter at 4)
      ui_in[0] = 1'b1;
      tick(1);
      ui_in[0] = 1'b0;
      tick(6);
      checkOutput("mid stretch", {7'b0, uoA[0]}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset uo_out A", uoA, 8'h00);
      checkOutput("async reset uio_out A", uioA, 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      checkOutput("post reset modes A", uoA, 8'hFF);
      checkOutput("post reset modes B", uoB, 8'h0F);
      tick(2);

      // Reset in the middle of a write
      uio_in = {1'b1, 3'd3, M_PASS, 2'b00};
      tick(2);
      rst_n  = 1'b0;
      uio_in = 8'h00;
      tick(2);
      rst_n = 1'b1;
      aA = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         aA += int'(uioA[0]);
      end
      checkOutput("no ack after reset", 8'(aA), 8'd0);
      checkOutput("write aborted", uoA, 8'hFF);

      // Randomised traffic
      for (int it = 0; it < 30; it++) begin
         int idx;
         idx = int'($urandom_range(0, 7));
         cfgWrite(idx, 2'($urandom_range(0, 3)), 1, aA, aB);
         checkOutput("rand ack A", 8'(aA), 8'd1);
         checkOutput("rand ack B", 8'(aB), (idx < NCH_B) ? 8'd1 : 8'd0);
         for (int c = 0; c < 12; c++) applyStimulus(8'($urandom), 1);
         if ((it % 5) == 4) applyStimulus(8'h00, 12);
      end

      checkOutput("uo_out B upper bits", {7'b0, hiB}, 8'd0);
      checkOutput("uio_oe A final", oeA, 8'h03);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
